// File: rtl/cnn_axi_pkg.sv
// Shared widths, lane geometry and packer state encoding for the CNN-to-AXI output path.
// Also carries the default per-layer OFM word counts.
package cnn_axi_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int AXI_WIDTH  = 256;
    localparam int LANES      = AXI_WIDTH / DATA_WIDTH;
    localparam int WCNT_WIDTH = 20;

    // Default layer sizes in 256-bit words: one tile row block, and a full 256-channel layer.
    localparam int OFM_TILE_WORDS = 338;
    localparam int NUM_TRANS_OFM  = 338 * 256;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } packer_state_t;

endpackage

// File: rtl/ofm_word_packer.sv
// Packs DATA_WIDTH-bit OFM pixels into AXI_WIDTH-bit words for the AXI write FIFO,
// with end-of-tile zero-padded flush and per-layer word counting.
module ofm_word_packer #(
    parameter int DATA_WIDTH = cnn_axi_pkg::DATA_WIDTH,
    parameter int AXI_WIDTH  = cnn_axi_pkg::AXI_WIDTH,
    parameter int WCNT_WIDTH = cnn_axi_pkg::WCNT_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  clear,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_last,
    input  logic                  fifo_ready,
    output logic [AXI_WIDTH-1:0]  wdata_out,
    output logic                  write,
    input  logic [WCNT_WIDTH-1:0] words_total,
    output logic [WCNT_WIDTH-1:0] word_cnt,
    output logic                  layer_done
);
    import cnn_axi_pkg::*;

    localparam int NLANES    = AXI_WIDTH / DATA_WIDTH;
    localparam int LANE_BITS = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NLANES - 1);

    packer_state_t         state_r;
    packer_state_t         state_nx_s;
    logic [AXI_WIDTH-1:0]  acc_r;
    logic [AXI_WIDTH-1:0]  out_reg_r;
    logic                  out_valid_r;
    logic [LANE_BITS-1:0]  lane_idx_r;
    logic [WCNT_WIDTH-1:0] word_cnt_r;
    logic                  layer_done_r;

    logic                  pix_ready_s;
    logic                  write_s;
    logic                  accept_s;
    logic                  complete_s;
    logic                  done_hit_s;
    logic [AXI_WIDTH-1:0]  merged_s;

    function automatic logic [AXI_WIDTH-1:0] lane_insert(
        input logic [AXI_WIDTH-1:0]  word,
        input logic [LANE_BITS-1:0]  idx,
        input logic [DATA_WIDTH-1:0] pix
    );
        logic [AXI_WIDTH-1:0] res;
        res = word;
        for (int k = 0; k < NLANES; k++) begin
            res[k*DATA_WIDTH +: DATA_WIDTH] = (idx == LANE_BITS'(k)) ? pix : word[k*DATA_WIDTH +: DATA_WIDTH];
        end
        return res;
    endfunction

    // Handshake, completion detect and end-of-layer detect.
    always_comb begin
        pix_ready_s = 1'b0;
        write_s     = 1'b0;
        if (state_r == RUN) begin
            // The pending slot drains in the same cycle it may be refilled.
            pix_ready_s = !out_valid_r || fifo_ready;
            write_s     = out_valid_r && fifo_ready;
        end else begin
            pix_ready_s = 1'b0;
            write_s     = 1'b0;
        end
        accept_s   = pix_valid && pix_ready_s;
        complete_s = accept_s && ((lane_idx_r == LAST_LANE) || pix_last);
        merged_s   = lane_insert(acc_r, lane_idx_r, pix_data);
        done_hit_s = write_s && (words_total != {WCNT_WIDTH{1'b0}})
                     && ((word_cnt_r + WCNT_WIDTH'(1'b1)) == words_total);
    end

    // Next-state logic: DONE is sticky until reset or clear.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            RUN: begin
                if (done_hit_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = DONE;
            default: state_nx_s = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= RUN;
        end else if (clear) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator and lane pointer; acc returns to zero on completion so flush padding is zero.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acc_r      <= {AXI_WIDTH{1'b0}};
            lane_idx_r <= {LANE_BITS{1'b0}};
        end else if (clear) begin
            acc_r      <= {AXI_WIDTH{1'b0}};
            lane_idx_r <= {LANE_BITS{1'b0}};
        end else if (complete_s) begin
            acc_r      <= {AXI_WIDTH{1'b0}};
            lane_idx_r <= {LANE_BITS{1'b0}};
        end else if (accept_s) begin
            acc_r      <= merged_s;
            lane_idx_r <= lane_idx_r + LANE_BITS'(1'b1);
        end
    end

    // Single pending-word slot; a reload in the write cycle keeps it occupied without a bubble.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_reg_r   <= {AXI_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (clear) begin
            out_reg_r   <= {AXI_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_reg_r   <= merged_s;
            out_valid_r <= 1'b1;
        end else if (write_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Word counter (wraps) and one-cycle layer_done pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            word_cnt_r   <= {WCNT_WIDTH{1'b0}};
            layer_done_r <= 1'b0;
        end else if (clear) begin
            word_cnt_r   <= {WCNT_WIDTH{1'b0}};
            layer_done_r <= 1'b0;
        end else begin
            if (write_s) begin
                word_cnt_r <= word_cnt_r + WCNT_WIDTH'(1'b1);
            end
            layer_done_r <= done_hit_s;
        end
    end

    assign pix_ready  = pix_ready_s;
    assign write      = write_s;
    assign wdata_out  = out_reg_r;
    assign word_cnt   = word_cnt_r;
    assign layer_done = layer_done_r;

endmodule

// File: tb/tb_ofm_word_packer.sv
// Scoreboard bench for ofm_word_packer: accepted pixels are grouped into expected words by a
// pixel-list model; a monitor pops and compares every write, word_cnt and layer_done.
`timescale 1ns/1ps
module tb_ofm_word_packer;
    localparam int DW = 16;
    localparam int AW = 256;
    localparam int CW = 20;
    localparam int NL = AW / DW;

    typedef struct {
        logic [AW-1:0] data;
        int            min_cyc;
        bit            exact;
    } exp_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          clear = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          fifo_ready;
    logic [AW-1:0] wdata_out;
    logic          write;
    logic [CW-1:0] words_total = '0;
    logic [CW-1:0] word_cnt;
    logic          layer_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fr_mode = 0;
    bit exact_mode = 1'b1;
    bit chk_spacing = 1'b0;
    int stalls = 0;
    int writes_seen = 0;
    int ld_pulses = 0;
    logic [DW-1:0] pend_q[$];
    exp_t exp_q[$];

    ofm_word_packer dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .clear(clear),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .fifo_ready(fifo_ready), .wdata_out(wdata_out), .write(write),
        .words_total(words_total), .word_cnt(word_cnt), .layer_done(layer_done)
    );

    initial forever #5 ACLK = ~ACLK;
    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    function automatic void chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: an accepted pixel list becomes a word at 16 pixels or at pix_last, zero-padded.
    function automatic void model_accept(input logic [DW-1:0] d, input bit last, input int c);
        exp_t e;
        pend_q.push_back(d);
        if (last || pend_q.size() == NL) begin
            e.data = '0;
            foreach (pend_q[i]) e.data[i*DW +: DW] = pend_q[i];
            e.min_cyc = c + 1;
            e.exact   = exact_mode;
            exp_q.push_back(e);
            pend_q.delete();
        end
    endfunction

    task automatic send_pix(input logic [DW-1:0] d, input bit last, input int budget, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        while (!ok && waited < budget) begin
            @(negedge ACLK);
            if (pix_ready) begin
                ok = 1'b1;
                model_accept(d, last, cyc);
            end else begin
                waited++;
                stalls++;
            end
            @(posedge ACLK);
            #1;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        pix_data  = DW'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last);
        bit ok;
        send_pix(d, last, 200, ok);
        chk("accept_timeout", {{(AW-1){1'b0}}, ok}, 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge ACLK);
        #1;
        clear = 1'b0;
        pend_q.delete();
    endtask

    // Downstream FIFO readiness driver.
    initial begin
        fifo_ready = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (fr_mode)
                0:       fifo_ready = 1'b1;
                1:       fifo_ready = ($urandom_range(0, 3) != 0);
                default: fifo_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every write and tracks word count / layer_done.
    initial begin
        logic [CW-1:0] model_cnt;
        bit exp_ld;
        bit sp_valid;
        int last_wr;
        exp_t e;
        model_cnt = '0;
        exp_ld = 1'b0;
        sp_valid = 1'b0;
        last_wr = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                model_cnt = '0;
                exp_ld = 1'b0;
                sp_valid = 1'b0;
            end else begin
                chk("word_cnt", word_cnt, model_cnt);
                if (exp_ld || layer_done) chk("layer_done", layer_done, exp_ld);
                if (layer_done) ld_pulses++;
                exp_ld = 1'b0;
                if (write) begin
                    writes_seen++;
                    chk("write_while_fifo_full", write & ~fifo_ready, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", write, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wdata", wdata_out, e.data);
                        if (e.exact) chk("write_latency", cyc, e.min_cyc);
                        else chk("write_not_early", cyc >= e.min_cyc, 1);
                    end
                    if (chk_spacing) begin
                        if (sp_valid) chk("write_spacing", cyc - last_wr, 16);
                        sp_valid = 1'b1;
                        last_wr = cyc;
                    end
                    model_cnt = model_cnt + 1'b1;
                    exp_ld = (words_total != '0) && (model_cnt == words_total);
                end
                if (!chk_spacing) sp_valid = 1'b0;
                if (clear) begin
                    model_cnt = '0;
                    exp_ld = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int w0;
        int l0;
        bit ok;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("reset_pix_ready", pix_ready, 1);
        chk("reset_write", write, 0);
        chk("reset_word_cnt", word_cnt, 0);
        chk("reset_layer_done", layer_done, 0);
        @(posedge ACLK);
        #1;

        // Full word back-to-back.
        exact_mode = 1'b1;
        stalls = 0;
        w0 = writes_seen;
        for (int i = 1; i <= 16; i++) send(DW'(i), 1'b0);
        drain(40);
        chk("t1_writes", writes_seen - w0, 1);
        chk("t1_no_stall", stalls, 0);

        // Short tile flush, then next word starts at lane 0.
        w0 = writes_seen;
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        send(16'hCCCC, 1'b1);
        send(16'h1234, 1'b1);
        drain(40);
        chk("t2_writes", writes_seen - w0, 2);

        // Backpressure while the first word is pending.
        exact_mode = 1'b0;
        stalls = 0;
        w0 = writes_seen;
        fork
            begin
                for (int i = 0; i < 32; i++) send(DW'($urandom), 1'b0);
            end
            begin
                repeat (13) @(posedge ACLK);
                fr_mode = 2;
                repeat (5) @(posedge ACLK);
                fr_mode = 0;
            end
        join
        drain(60);
        chk("t3_writes", writes_seen - w0, 2);
        chk("t3_pix_ready_dropped", stalls > 0, 1);

        // Randomized gaps, tile ends and FIFO readiness.
        fr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge ACLK);
                #1;
            end
            send(DW'($urandom), $urandom_range(0, 7) == 0);
        end
        fr_mode = 0;
        drain(100);

        // Asynchronous reset mid-word discards the partial word.
        exact_mode = 1'b1;
        for (int i = 0; i < 7; i++) send(DW'($urandom), 1'b0);
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        pend_q.delete();
        w0 = writes_seen;
        for (int i = 0; i < 16; i++) send(DW'(16'h0100 + i), 1'b0);
        drain(40);
        chk("t5_writes", writes_seen - w0, 1);

        // Bounded layer of two words.
        words_total = CW'(2);
        pulse_clear();
        w0 = writes_seen;
        l0 = ld_pulses;
        for (int i = 0; i < 40; i++) send_pix(DW'($urandom), 1'b0, 3, ok);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("t4_pix_ready_low", pix_ready, 0);
        chk("t4_word_cnt", word_cnt, 2);
        chk("t4_writes", writes_seen - w0, 2);
        chk("t4_layer_done_pulses", ld_pulses - l0, 1);
        @(posedge ACLK);
        #1;
        words_total = CW'(338);
        pulse_clear();
        @(negedge ACLK);
        chk("t4_clear_word_cnt", word_cnt, 0);
        chk("t4_clear_pix_ready", pix_ready, 1);
        @(posedge ACLK);
        #1;

        // Sustained layer of 338 words.
        chk_spacing = 1'b1;
        w0 = writes_seen;
        l0 = ld_pulses;
        for (int i = 0; i < 16 * 338; i++) send(DW'($urandom), 1'b0);
        drain(40);
        repeat (3) @(posedge ACLK);
        #1;
        chk_spacing = 1'b0;
        chk("t6_writes", writes_seen - w0, 338);
        chk("t6_layer_done_pulses", ld_pulses - l0, 1);
        chk("t6_pix_ready_low_after_layer", pix_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
